// File: rtl/freq_reg_pkg.sv
// Shared definitions for the divisor regulation loop: default width,
// reset divisor derivation and saturating arithmetic helpers.
package freq_reg_pkg;

    localparam int unsigned W_DEFAULT = 8;

    // Mid-scale minus one, so the loop starts with headroom in both directions.
    function automatic int unsigned div_init(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // a + b, clamped to hi. Evaluated one bit wider so the sum never wraps.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] hi
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, hi}) begin
            return hi;
        end
        return s[31:0];
    endfunction

    // a - b, clamped to lo. Evaluated one bit wider so the difference never wraps.
    function automatic logic [31:0] sat_sub(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] lo
    );
        if ({1'b0, a} < ({1'b0, b} + {1'b0, lo})) begin
            return lo;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/pulse_width_meter.sv
// Measures the high time of psi in clk cycles. A measurement is presented
// for one cycle on the falling edge of a pulse whose rise was seen while
// regulation was enabled. psi_q starts high out of reset so a pulse that is
// already high at reset release can never be measured.
module pulse_width_meter
    import freq_reg_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         psi,
    output logic         meas_valid,
    output logic [W-1:0] meas_value,
    output logic         meas_ovf
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic         psi_q;     // psi delayed by one cycle
    logic         armed_q;
    logic         armed_d;
    logic [W-1:0] dur_q;
    logic [W-1:0] dur_d;

    // Edge classification on {psi_q, psi} drives the counter and arming.
    always_comb begin
        armed_d = armed_q;
        dur_d   = dur_q;
        unique case ({psi_q, psi})
            2'b01: begin
                dur_d = W'(1);
                if (en) begin
                    armed_d = 1'b1;
                end
            end
            2'b11: dur_d = W'(sat_add(32'(dur_q), 32'd1, 32'(CNT_MAX)));
            2'b10: armed_d = 1'b0;
            default: ;
        endcase
        if (!en) begin
            armed_d = 1'b0;
        end
    end

    // Measurement state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            psi_q   <= 1'b1;
            armed_q <= 1'b0;
            dur_q   <= '0;
        end else begin
            psi_q   <= psi;
            armed_q <= armed_d;
            dur_q   <= dur_d;
        end
    end

    // Decided in the fall cycle itself; the regulator registers the result.
    assign meas_valid = armed_q & psi_q & ~psi & en;
    assign meas_value = dur_q;
    assign meas_ovf   = (dur_q == CNT_MAX);

endmodule

// File: rtl/pulse_width_regulator.sv
// Closed-loop divisor regulator: compares each measured psi high time with
// setperiod and nudges the divisor up or down, with a deadband, saturation
// at 1 and 2^W-1, and a lock indication after consecutive in-band pulses.
module pulse_width_regulator
    import freq_reg_pkg::*;
#(
    parameter int unsigned W          = W_DEFAULT,
    parameter int unsigned DIV_INIT   = div_init(W),
    parameter int unsigned STEP       = 1,
    parameter int unsigned DEADBAND   = 0,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         psi,
    input  logic [W-1:0] setperiod,
    output logic         inc,
    output logic         dec,
    output logic [W-1:0] adjusteddiv,
    output logic         locked,
    output logic         ovf
);

    localparam int unsigned   LCW     = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]  DIV_MAX = '1;
    localparam logic [W-1:0]  DIV_RST = W'(DIV_INIT);
    localparam logic [LCW-1:0] LOCK_N = LCW'(LOCK_COUNT);

    logic         meas_valid;
    logic [W-1:0] meas_value;
    logic         meas_ovf;

    logic           inc_q, inc_d;
    logic           dec_q, dec_d;
    logic [W-1:0]   div_q, div_d;
    logic           locked_q, locked_d;
    logic           ovf_q, ovf_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

    logic [W:0] dur_x;
    logic [W:0] dur_hi;
    logic [W:0] sp_x;
    logic [W:0] sp_hi;
    logic       too_long;
    logic       too_short;

    pulse_width_meter #(
        .W (W)
    ) u_meter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .psi        (psi),
        .meas_valid (meas_valid),
        .meas_value (meas_value),
        .meas_ovf   (meas_ovf)
    );

    // One bit wider than the operands so adding the deadband cannot wrap.
    always_comb begin
        dur_x     = {1'b0, meas_value};
        sp_x      = {1'b0, setperiod};
        dur_hi    = dur_x + (W+1)'(DEADBAND);
        sp_hi     = sp_x + (W+1)'(DEADBAND);
        too_long  = dur_x > sp_hi;
        too_short = dur_hi < sp_x;
    end

    // Correction and lock decision for each measurement.
    always_comb begin
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        div_d      = div_q;
        ovf_d      = ovf_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (!en) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (meas_valid) begin
            ovf_d = meas_ovf;
            if (too_long) begin
                inc_d      = 1'b1;
                div_d      = W'(sat_add(32'(div_q), STEP, 32'(DIV_MAX)));
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end else if (too_short) begin
                dec_d      = 1'b1;
                div_d      = W'(sat_sub(32'(div_q), STEP, 32'd1));
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end else begin
                if (lock_cnt_q < LOCK_N) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
                locked_d = (lock_cnt_d == LOCK_N);
            end
        end
    end

    // Output and lock registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            div_q      <= DIV_RST;
            locked_q   <= 1'b0;
            ovf_q      <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            div_q      <= div_d;
            locked_q   <= locked_d;
            ovf_q      <= ovf_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign inc         = inc_q;
    assign dec         = dec_q;
    assign adjusteddiv = div_q;
    assign locked      = locked_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_pulse_width_regulator.sv
// Scoreboard bench: three regulator instances (default, deadband 2,
// step 4). Expected corrections are queued when a pulse is issued; monitors
// pop and compare whenever an instance pulses inc or dec.
module tb_pulse_width_regulator;

    typedef struct packed {
        logic       inc;
        logic       dec;
        logic [7:0] div;
        logic       locked;
        logic       ovf;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic psi_a, psi_b, psi_c;
    logic [7:0] sp_a, sp_b, sp_c;
    logic inc_a, dec_a, locked_a, ovf_a;
    logic inc_b, dec_b, locked_b, ovf_b;
    logic inc_c, dec_c, locked_c, ovf_c;
    logic [7:0] div_a, div_b, div_c;

    int n_checks = 0;
    int n_fail   = 0;

    resp_t q_a[$];
    resp_t q_b[$];
    resp_t q_c[$];

    always #5 clk = ~clk;

    pulse_width_regulator u_a (
        .clk(clk), .rst(rst), .en(en), .psi(psi_a), .setperiod(sp_a),
        .inc(inc_a), .dec(dec_a), .adjusteddiv(div_a), .locked(locked_a), .ovf(ovf_a)
    );

    pulse_width_regulator #(.DEADBAND(2), .LOCK_COUNT(4)) u_b (
        .clk(clk), .rst(rst), .en(en), .psi(psi_b), .setperiod(sp_b),
        .inc(inc_b), .dec(dec_b), .adjusteddiv(div_b), .locked(locked_b), .ovf(ovf_b)
    );

    pulse_width_regulator #(.STEP(4)) u_c (
        .clk(clk), .rst(rst), .en(en), .psi(psi_c), .setperiod(sp_c),
        .inc(inc_c), .dec(dec_c), .adjusteddiv(div_c), .locked(locked_c), .ovf(ovf_c)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_resp(input string nm, input resp_t act, input resp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got inc=%0b dec=%0b div=%0d locked=%0b ovf=%0b, want inc=%0b dec=%0b div=%0d locked=%0b ovf=%0b",
                     nm, act.inc, act.dec, act.div, act.locked, act.ovf,
                     exp.inc, exp.dec, exp.div, exp.locked, exp.ovf);
        end
    endtask

    task automatic spurious(input string nm, input resp_t act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected correction inc=%0b dec=%0b div=%0d, want none",
                 nm, act.inc, act.dec, act.div);
    endtask

    // Monitors: one per instance, sampling on the falling edge.
    always @(negedge clk) begin
        if (inc_a | dec_a) begin
            if (q_a.size() == 0) spurious("a_corr", {inc_a, dec_a, div_a, locked_a, ovf_a});
            else cmp_resp("a_corr", {inc_a, dec_a, div_a, locked_a, ovf_a}, q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (inc_b | dec_b) begin
            if (q_b.size() == 0) spurious("b_corr", {inc_b, dec_b, div_b, locked_b, ovf_b});
            else cmp_resp("b_corr", {inc_b, dec_b, div_b, locked_b, ovf_b}, q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (inc_c | dec_c) begin
            if (q_c.size() == 0) spurious("c_corr", {inc_c, dec_c, div_c, locked_c, ovf_c});
            else cmp_resp("c_corr", {inc_c, dec_c, div_c, locked_c, ovf_c}, q_c.pop_front());
        end
    end

    task automatic push(input int which, input bit i, input bit d, input int dv,
                        input bit lk, input bit ov);
        resp_t r;
        r = {i, d, 8'(dv), lk, ov};
        case (which)
            0: q_a.push_back(r);
            1: q_b.push_back(r);
            default: q_c.push_back(r);
        endcase
    endtask

    task automatic set_psi(input int which, input logic v);
        case (which)
            0: psi_a = v;
            1: psi_b = v;
            default: psi_c = v;
        endcase
    endtask

    // Called at a falling edge; psi is sampled high on exactly hi rising edges.
    task automatic pulse(input int which, input int hi, input int lo);
        set_psi(which, 1'b1);
        repeat (hi) @(negedge clk);
        set_psi(which, 1'b0);
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b0;
        en    = 1'b1;
        psi_a = 1'b0;
        psi_b = 1'b0;
        psi_c = 1'b0;
        sp_a  = 8'd10;
        sp_b  = 8'd10;
        sp_c  = 8'd10;

        // Reset with psi toggling.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            psi_a = ~psi_a;
            @(negedge clk);
        end
        check("rst_div_a", div_a, 127);
        check("rst_div_b", div_b, 127);
        check("rst_div_c", div_c, 127);
        check("rst_flags_a", {inc_a, dec_a, locked_a, ovf_a}, 0);
        check("rst_flags_c", {inc_c, dec_c, locked_c, ovf_c}, 0);

        // psi already high at reset release: its fall must do nothing.
        psi_a = 1'b1;
        rst   = 1'b1;
        repeat (5) @(negedge clk);
        psi_a = 1'b0;
        repeat (3) @(negedge clk);
        check("a_prehigh_div", div_a, 127);

        // Corrections in both directions, then an exact match.
        push(0, 1, 0, 128, 0, 0);
        pulse(0, 12, 3);
        push(0, 0, 1, 127, 0, 0);
        pulse(0, 8, 3);
        pulse(0, 10, 3);
        check("a_exact_div", div_a, 127);
        check("a_exact_lock", locked_a, 0);

        // Disabled across a whole pulse.
        en = 1'b0;
        pulse(0, 12, 3);
        en = 1'b1;
        @(negedge clk);
        check("a_en0_div", div_a, 127);

        // Enable raised mid-pulse: that pulse is ignored.
        en = 1'b0;
        psi_a = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (9) @(negedge clk);
        psi_a = 1'b0;
        repeat (3) @(negedge clk);
        check("a_en_mid_div", div_a, 127);

        // Counter saturation, then drive the divisor to its ceiling.
        push(0, 1, 0, 128, 0, 1);
        pulse(0, 300, 3);
        for (int k = 129; k <= 255; k++) begin
            push(0, 1, 0, k, 0, 0);
            pulse(0, 12, 3);
        end
        check("a_div_max", div_a, 255);
        for (int k = 0; k < 2; k++) begin
            push(0, 1, 0, 255, 0, 0);
            pulse(0, 20, 3);
        end

        // Minimum-width pulses back to back.
        push(0, 0, 1, 254, 0, 0);
        pulse(0, 1, 1);
        push(0, 0, 1, 253, 0, 0);
        pulse(0, 1, 3);
        check("a_b2b_div", div_a, 253);

        // Two more corrections, then reset in the middle of a long pulse.
        push(0, 0, 1, 252, 0, 0);
        pulse(0, 8, 3);
        push(0, 1, 0, 253, 0, 1);
        pulse(0, 300, 3);
        check("a_pre_rst_ovf", ovf_a, 1);
        psi_a = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("a_midrst_div", div_a, 127);
        check("a_midrst_ovf", ovf_a, 0);
        rst = 1'b1;
        repeat (29) @(negedge clk);
        psi_a = 1'b0;
        repeat (4) @(negedge clk);
        check("a_after_rst_div", div_a, 127);

        // Deadband 2, lock after four in-band pulses.
        for (int k = 1; k <= 4; k++) begin
            pulse(1, 11, 3);
            check($sformatf("b_lock_%0d", k), locked_b, (k == 4) ? 1 : 0);
        end
        check("b_inband_div", div_b, 127);
        push(1, 1, 0, 128, 0, 0);
        pulse(1, 20, 3);
        pulse(1, 12, 3);
        check("b_edge_hi_div", div_b, 128);
        push(1, 1, 0, 129, 0, 0);
        pulse(1, 13, 3);
        pulse(1, 8, 3);
        check("b_edge_lo_div", div_b, 129);
        push(1, 0, 1, 128, 0, 0);
        pulse(1, 7, 3);

        // Step 4 walking down to the floor.
        for (int k = 1; k <= 31; k++) begin
            push(2, 0, 1, 127 - 4 * k, 0, 0);
            pulse(2, 3, 3);
        end
        push(2, 0, 1, 1, 0, 0);
        pulse(2, 3, 3);
        push(2, 0, 1, 1, 0, 0);
        pulse(2, 3, 3);
        check("c_floor_div", div_c, 1);
        push(2, 1, 0, 5, 0, 0);
        pulse(2, 12, 3);

        repeat (5) @(negedge clk);
        check("a_queue_left", q_a.size(), 0);
        check("b_queue_left", q_b.size(), 0);
        check("c_queue_left", q_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
